// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM stepping each instruction through fetch/decode/execute states.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3, unknown op 2 cycles; no backpressure, outputs decode the current state.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] ADDIEXEC = 4'd9;
  localparam logic [3:0] ADDIWB   = 4'd10;
  localparam logic [3:0] JUMP     = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] cur_state;
  logic [3:0] nxt_state;
  logic [2:0] funct_alu;

  assign state = cur_state;

  always_ff @(posedge clk) begin
    if (reset) cur_state <= FETCH;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = FETCH;
    case (cur_state)
      FETCH:  nxt_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_RTYP:      nxt_state = EXECUTE;
          OP_BEQ:       nxt_state = BRANCH;
          OP_ADDI:      nxt_state = ADDIEXEC;
          OP_J:         nxt_state = JUMP;
          default:      nxt_state = FETCH;
        endcase
      end
      MEMADR:   nxt_state = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    nxt_state = MEMWB;
      EXECUTE:  nxt_state = ALUWB;
      ADDIEXEC: nxt_state = ADDIWB;
      default:  nxt_state = FETCH;
    endcase
  end

  always_comb begin
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    pcen       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    case (cur_state)
      FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = 1'b1;
        pcen       = 1'b1;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
      end
      ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    // Architectural strobes must never fire while reset holds the machine.
    if (reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks every instruction class and reset cases, checking hand-derived outputs.
module tb_mc_controller;
  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite;
  logic       alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    funct = 6'b000000;
    zero  = 1'b0;

    // Reset held two cycles: FETCH state, strobes forced low, datapath selects follow state.
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pcen", 32'(pcen), 32'd0);
    chk("rst_irwrite", 32'(irwrite), 32'd0);
    chk("rst_alusrcb", 32'(alusrcb), 32'd1);
    chk("rst_aluctl", 32'(alucontrol), 32'd2);
    reset = 1'b0;
    op    = 6'b100011;
    #1;
    chk("fetch_pcen", 32'(pcen), 32'd1);
    chk("fetch_irwrite", 32'(irwrite), 32'd1);
    chk("fetch_iord", 32'(iord), 32'd0);

    // lw: 0,1,2,3,4,0
    tick();
    chk("lw_s1", 32'(state), 32'd1);
    chk("lw_dec_alusrcb", 32'(alusrcb), 32'd3);
    chk("lw_dec_pcen", 32'(pcen), 32'd0);
    tick();
    chk("lw_s2", 32'(state), 32'd2);
    chk("lw_adr_alusrca", 32'(alusrca), 32'd1);
    chk("lw_adr_alusrcb", 32'(alusrcb), 32'd2);
    tick();
    chk("lw_s3", 32'(state), 32'd3);
    chk("lw_rd_iord", 32'(iord), 32'd1);
    chk("lw_rd_regwrite", 32'(regwrite), 32'd0);
    tick();
    chk("lw_s4", 32'(state), 32'd4);
    chk("lw_wb_regwrite", 32'(regwrite), 32'd1);
    chk("lw_wb_memtoreg", 32'(memtoreg), 32'd1);
    chk("lw_wb_regdst", 32'(regdst), 32'd0);
    tick();
    chk("lw_s0", 32'(state), 32'd0);
    chk("lw_end_regwrite", 32'(regwrite), 32'd0);

    // R-type slt, plus funct decode while in EXECUTE
    op    = 6'b000000;
    funct = 6'b101010;
    tick();
    chk("r_s1", 32'(state), 32'd1);
    tick();
    chk("r_s6", 32'(state), 32'd6);
    chk("r_slt", 32'(alucontrol), 32'd7);
    chk("r_alusrcb", 32'(alusrcb), 32'd0);
    chk("r_alusrca", 32'(alusrca), 32'd1);
    funct = 6'b100010;
    #1;
    chk("r_sub", 32'(alucontrol), 32'd6);
    funct = 6'b100101;
    #1;
    chk("r_or", 32'(alucontrol), 32'd1);
    funct = 6'b111111;
    #1;
    chk("r_other", 32'(alucontrol), 32'd2);
    funct = 6'b101010;
    tick();
    chk("r_s7", 32'(state), 32'd7);
    chk("r_wb_regwrite", 32'(regwrite), 32'd1);
    chk("r_wb_regdst", 32'(regdst), 32'd1);
    chk("r_wb_memtoreg", 32'(memtoreg), 32'd0);
    tick();
    chk("r_s0", 32'(state), 32'd0);

    // beq taken then not taken
    op   = 6'b000100;
    zero = 1'b1;
    tick();
    chk("beq1_s1", 32'(state), 32'd1);
    chk("beq1_dec_pcen", 32'(pcen), 32'd0);
    tick();
    chk("beq1_s8", 32'(state), 32'd8);
    chk("beq1_pcen", 32'(pcen), 32'd1);
    chk("beq1_pcsrc", 32'(pcsrc), 32'd1);
    chk("beq1_aluctl", 32'(alucontrol), 32'd6);
    tick();
    chk("beq1_s0", 32'(state), 32'd0);
    zero = 1'b0;
    tick();
    tick();
    chk("beq0_s8", 32'(state), 32'd8);
    chk("beq0_pcen", 32'(pcen), 32'd0);
    chk("beq0_pcsrc", 32'(pcsrc), 32'd1);
    tick();
    chk("beq0_s0", 32'(state), 32'd0);

    // sw: 0,1,2,5,0
    op = 6'b101011;
    tick();
    chk("sw_s1", 32'(state), 32'd1);
    chk("sw_dec_memwrite", 32'(memwrite), 32'd0);
    tick();
    chk("sw_s2", 32'(state), 32'd2);
    chk("sw_adr_memwrite", 32'(memwrite), 32'd0);
    tick();
    chk("sw_s5", 32'(state), 32'd5);
    chk("sw_memwrite", 32'(memwrite), 32'd1);
    chk("sw_iord", 32'(iord), 32'd1);
    chk("sw_regwrite", 32'(regwrite), 32'd0);
    tick();
    chk("sw_s0", 32'(state), 32'd0);
    chk("sw_end_memwrite", 32'(memwrite), 32'd0);

    // Reset arriving in MEMWR kills the write strobe and returns to FETCH.
    tick();
    tick();
    tick();
    chk("swr_s5", 32'(state), 32'd5);
    reset = 1'b1;
    #1;
    chk("swr_memwrite", 32'(memwrite), 32'd0);
    chk("swr_iord", 32'(iord), 32'd1);
    tick();
    chk("swr_s0", 32'(state), 32'd0);
    chk("swr_pcen_held", 32'(pcen), 32'd0);
    reset = 1'b0;
    op    = 6'b111111;
    #1;
    chk("swr_pcen", 32'(pcen), 32'd1);

    // Unknown opcode: DECODE then FETCH, no write strobes.
    tick();
    chk("unk_s1", 32'(state), 32'd1);
    chk("unk_regwrite", 32'(regwrite), 32'd0);
    chk("unk_memwrite", 32'(memwrite), 32'd0);
    tick();
    chk("unk_s0", 32'(state), 32'd0);

    // addi: 0,1,9,10,0
    op = 6'b001000;
    tick();
    tick();
    chk("addi_s9", 32'(state), 32'd9);
    chk("addi_alusrcb", 32'(alusrcb), 32'd2);
    chk("addi_alusrca", 32'(alusrca), 32'd1);
    tick();
    chk("addi_s10", 32'(state), 32'd10);
    chk("addi_regwrite", 32'(regwrite), 32'd1);
    chk("addi_regdst", 32'(regdst), 32'd0);
    tick();
    chk("addi_s0", 32'(state), 32'd0);

    // j: 0,1,11,0
    op = 6'b000010;
    tick();
    tick();
    chk("j_s11", 32'(state), 32'd11);
    chk("j_pcsrc", 32'(pcsrc), 32'd2);
    chk("j_pcen", 32'(pcen), 32'd1);
    chk("j_irwrite", 32'(irwrite), 32'd0);
    tick();
    chk("j_s0", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
Parameters: none.
REQ-001 clk  in  1  single clock, all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising clk.
REQ-003 op  in  6  opcode, instr[31:26], from instruction register.
REQ-004 funct  in  6  function field, instr[5:0].
REQ-005 zero  in  1  ALU zero flag, same cycle as alucontrol.
REQ-006 pcen  out  1  PC register load enable.
REQ-007 memwrite  out  1  data memory write strobe.
REQ-008 irwrite  out  1  instruction register load enable.
REQ-009 regwrite  out  1  register file write strobe.
REQ-010 alusrca  out  1  ALU A select: 0=PC, 1=register A.
REQ-011 iord  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-012 memtoreg  out  1  writeback select: 0=ALUOut, 1=memory data.
REQ-013 regdst  out  1  destination select: 0=rt, 1=rd.
REQ-014 alusrcb  out  2  ALU B select: 00=regB, 01=const 4, 10=sign-ext imm, 11=imm<<2.
REQ-015 pcsrc  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-016 alucontrol  out  3  ALU operation code, drives ALU ALUControl input directly.
REQ-017 state  out  4  current state encoding, debug/verification only.

Function
REQ-018 The block SHALL be a Moore FSM; all outputs SHALL be combinational from state (plus funct for alucontrol, zero for pcen); unlisted outputs SHALL be 0 in each state.
REQ-019 Encodings SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH next cycle with all outputs 0.
REQ-020 ALU codes SHALL be: and=000, or=001, add=010, sub=110, slt=111.
REQ-021 FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite=1, pcen=1; next DECODE.
REQ-022 DECODE: alusrca=0, alusrcb=11, alucontrol=010; next by op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEXEC, 000010->JUMP, any other->FETCH.
REQ-023 MEMADR: alusrca=1, alusrcb=10, alucontrol=010; next MEMRD if op=100011, else MEMWR.
REQ-024 MEMRD: iord=1; next MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-025 MEMWR: iord=1, memwrite=1; next FETCH.
REQ-026 EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010; next ALUWB.
REQ-027 ALUWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
REQ-028 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero; next FETCH.
REQ-029 ADDIEXEC: alusrca=1, alusrcb=10, alucontrol=010; next ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
REQ-030 JUMP: pcsrc=10, pcen=1; next FETCH.
REQ-031 Latency SHALL be: lw 5 cycles, sw/R-type/addi 4, beq/j 3, unknown op 2.
REQ-032 Inputs op, funct, zero SHALL NOT be registered; no state other than the state register SHALL exist.

Reset
REQ-033 reset high at a rising edge SHALL load FETCH, overriding any transition, in any state including mid-instruction.
REQ-034 While reset is high, pcen, irwrite, memwrite, regwrite SHALL be forced 0 combinationally; other outputs follow state.
REQ-035 After reset deasserts, the first cycle SHALL be FETCH with pcen=1, irwrite=1.

Verification
REQ-036 reset 2 cycles, release, op=100011 -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-037 op=000000 funct=101010 -> EXECUTE alucontrol=111; ALUWB regwrite=1, regdst=1; back to FETCH after 4 cycles.
REQ-038 op=000100, zero=1 in BRANCH -> pcen=1, pcsrc=01; repeat with zero=0 -> pcen=0; both return to FETCH.
REQ-039 op=101011 -> states 0,1,2,5,0; memwrite=1 only in MEMWR, iord=1 there; regwrite never 1.
REQ-040 reset asserted while in MEMWR -> memwrite=0 that cycle, state=0 next cycle.
REQ-041 op=111111 -> DECODE then FETCH; no regwrite/memwrite pulses.
